// File: rtl/inst_mem_pkg.sv
// Shared types and address-split helpers for the instruction memory controller.
// The optional INST_MEM_FETCH_ERR_EN macro is consumed by inst_mem_ctrl, not here.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Byte-offset bits inside one instruction word
  function automatic int calc_bo(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int calc_iw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, one registered read port that holds its
// value between reads. No reset; the controller clears it with explicit writes.
module inst_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: clears memory after reset, loads a program
// word by word, and serves single-cycle-latency fetches. Define
// INST_MEM_FETCH_ERR_EN to report out-of-range/misaligned fetches on fetch_err.
module inst_mem_ctrl
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic              busy
);

  localparam int BO = calc_bo(DATA_W);
  localparam int IW = calc_iw(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     wr_ptr, wr_ptr_nxt;
  logic              load_done_nxt;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic              fetch_accept;
  logic [IW-1:0]     fetch_index;
  logic              in_range;
  logic              fetch_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_CLEAR;
      wr_ptr    <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      load_done <= load_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    load_done_nxt = 1'b0;
    mem_wr_en     = 1'b0;
    mem_wr_data   = '0;
    load_ready    = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_CLEAR: begin
        mem_wr_en  = 1'b1;
        wr_ptr_nxt = wr_ptr + IW'(1);
        if (wr_ptr == LAST_IDX) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          state_nxt  = ST_LOAD;
          wr_ptr_nxt = '0;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        // A full memory ends the load even without load_last
        if (load_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = load_data;
          wr_ptr_nxt  = wr_ptr + IW'(1);
          if (load_last || wr_ptr == LAST_IDX) begin
            state_nxt     = ST_IDLE;
            load_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = ST_CLEAR;
        wr_ptr_nxt = '0;
      end
    endcase
  end

  assign fetch_accept = (state == ST_IDLE) && fetch_req;
  assign fetch_index  = IW'(fetch_addr >> BO);
  assign in_range     = (fetch_addr >> (BO + IW)) == '0;

`ifdef INST_MEM_FETCH_ERR_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BO) - 1);
  logic aligned;
  assign aligned  = (fetch_addr & ALIGN_MASK) == '0;
  assign fetch_ok = in_range && aligned;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)           fetch_err <= 1'b0;
    else if (fetch_accept) fetch_err <= !fetch_ok;
  end
`else
  assign fetch_ok  = in_range;
  assign fetch_err = 1'b0;
`endif

  // data_ok masks rejected fetches to zero and, like rd_data, only moves on a fetch
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fetch_valid <= 1'b0;
      data_ok     <= 1'b0;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_accept) data_ok <= fetch_ok;
    end
  end

  assign fetch_data = data_ok ? rd_data : '0;

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_array (
    .sys_clk (sys_clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (mem_wr_data),
    .rd_en   (fetch_accept),
    .rd_addr (fetch_index),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl against a word-array reference model.
// Expected fetch_err follows whether INST_MEM_FETCH_ERR_EN is defined.
module tb_inst_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int WBYTES = DATA_W / 8;
`ifdef INST_MEM_FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              load_start, load_valid, load_ready, load_last, load_done;
  logic [DATA_W-1:0] load_data;
  logic              fetch_req, fetch_valid, fetch_err, busy;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [DATA_W-1:0] model_mem  [DEPTH];
  logic [DATA_W-1:0] load_words [32];

  always #5 sys_clk = ~sys_clk;

  inst_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .busy        (busy)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] addr);
    longint unsigned a = longint'(addr);
    bit in_range = a < longint'(DEPTH * WBYTES);
    bit aligned  = (a % WBYTES) == 0;
    int idx      = int'((a / WBYTES) % DEPTH);
    if (!in_range) return '0;
    if (ERR_EN && !aligned) return '0;
    return model_mem[idx];
  endfunction

  function automatic logic model_err(input logic [ADDR_W-1:0] addr);
    longint unsigned a = longint'(addr);
    return ERR_EN && (a >= longint'(DEPTH * WBYTES) || (a % WBYTES) != 0);
  endfunction

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, output logic v,
                               output logic [DATA_W-1:0] d, output logic e);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    step();
    fetch_req = 1'b0;
    v = fetch_valid;
    d = fetch_data;
    e = fetch_err;
  endtask

  task automatic drive_load(input int n, input int last_at, input bit gappy, input bit fetch_during,
                            output int accepted, output int done_pulses, output int fetch_valids,
                            output logic ready_after);
    int   idx;
    int   cycles;
    int   stall;
    bit   v;
    logic rdy;
    idx = 0; accepted = 0; done_pulses = 0; fetch_valids = 0;
    ready_after = 1'b1; cycles = 0; stall = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    while (idx < n && cycles < 300 && stall < 4) begin
      v          = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      load_valid = v;
      load_data  = load_words[idx];
      load_last  = (idx == last_at);
      fetch_req  = fetch_during;
      fetch_addr = ADDR_W'($urandom_range(0, 63));
      rdy        = load_ready;
      step();
      cycles++;
      if (load_done) done_pulses++;
      if (fetch_valid) fetch_valids++;
      if (v && rdy) begin
        accepted++;
        idx++;
        ready_after = load_ready;
      end
      if (!rdy) stall++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    repeat (2) begin
      step();
      if (load_done) done_pulses++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic v, e;
    logic [DATA_W-1:0] d;
    sys_rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
    repeat (3) step();
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
    n_compared++; if (load_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_load_ready: got %b want 0", load_ready); end
    n_compared++; if (fetch_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
    n_compared++; if (fetch_data !== '0) begin n_mismatched++; $display("[TB] FAIL reset_fetch_data: got %h want 0", fetch_data); end
    n_compared++; if (fetch_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_fetch_err: got %b want 0", fetch_err); end
    n_compared++; if (load_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_load_done: got %b want 0", load_done); end
    sys_rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
    end
    n_compared++; if (cnt != DEPTH) begin n_mismatched++; $display("[TB] FAIL clear_cycles: got %0d want %0d", cnt, DEPTH); end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    applyStimulus(32'h3C, v, d, e);
    n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL idle_fetch_valid: got %b want 1", v); end
    n_compared++; if (d !== 32'h0) begin n_mismatched++; $display("[TB] FAIL idle_fetch_data: got %h want 0", d); end
    n_compared++; if (e !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_fetch_err: got %b want 0", e); end
  endtask

  task automatic test_load_basic();
    int acc, dn, fv;
    logic ra, v, e;
    logic [DATA_W-1:0] d;
    load_words[0] = 32'h11; load_words[1] = 32'h22; load_words[2] = 32'h33;
    drive_load(3, 2, 1'b0, 1'b0, acc, dn, fv, ra);
    n_compared++; if (acc != 3) begin n_mismatched++; $display("[TB] FAIL basic_accepted: got %0d want 3", acc); end
    n_compared++; if (dn != 1) begin n_mismatched++; $display("[TB] FAIL basic_done_pulses: got %0d want 1", dn); end
    for (int i = 0; i < 3; i++) model_mem[i] = load_words[i];
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ADDR_W'(i * WBYTES), v, d, e);
      n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_valid[%0d]: got %b want 1", i, v); end
      n_compared++; if (d !== model_data(ADDR_W'(i * WBYTES))) begin n_mismatched++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", i, d, model_data(ADDR_W'(i * WBYTES))); end
    end
  endtask

  task automatic test_load_overflow();
    int acc, dn, fv;
    logic ra, v, e;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 20; i++) load_words[i] = $urandom | 32'h1;
    drive_load(20, -1, 1'b0, 1'b0, acc, dn, fv, ra);
    n_compared++; if (acc != DEPTH) begin n_mismatched++; $display("[TB] FAIL overflow_accepted: got %0d want %0d", acc, DEPTH); end
    n_compared++; if (dn != 1) begin n_mismatched++; $display("[TB] FAIL overflow_done_pulses: got %0d want 1", dn); end
    n_compared++; if (ra !== 1'b0) begin n_mismatched++; $display("[TB] FAIL overflow_ready_after: got %b want 0", ra); end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = load_words[i];
    applyStimulus(32'h3C, v, d, e);
    n_compared++; if (d !== load_words[15]) begin n_mismatched++; $display("[TB] FAIL overflow_word15: got %h want %h", d, load_words[15]); end
    for (int i = 0; i < 10; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1) * WBYTES);
      applyStimulus(a, v, d, e);
      n_compared++; if (d !== model_data(a)) begin n_mismatched++; $display("[TB] FAIL overflow_rand_data @%h: got %h want %h", a, d, model_data(a)); end
    end
  endtask

  task automatic test_fetch_err();
    logic v, e;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 26; i++) begin
      if (i == 0)      a = 32'h40;
      else if (i == 1) a = 32'h2;
      else if (i % 5 == 0) a = $urandom;
      else             a = ADDR_W'($urandom_range(0, 95));
      applyStimulus(a, v, d, e);
      n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL err_valid @%h: got %b want 1", a, v); end
      n_compared++; if (d !== model_data(a)) begin n_mismatched++; $display("[TB] FAIL err_data @%h: got %h want %h", a, d, model_data(a)); end
      n_compared++; if (e !== model_err(a)) begin n_mismatched++; $display("[TB] FAIL err_flag @%h: got %b want %b", a, e, model_err(a)); end
    end
  endtask

  task automatic test_fetch_hold();
    logic v, e;
    logic [DATA_W-1:0] d;
    applyStimulus(32'h14, v, d, e);
    repeat (2) step();
    n_compared++; if (fetch_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_valid: got %b want 0", fetch_valid); end
    n_compared++; if (fetch_data !== model_data(32'h14)) begin n_mismatched++; $display("[TB] FAIL hold_data: got %h want %h", fetch_data, model_data(32'h14)); end
    n_compared++; if (fetch_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_gappy_load();
    int acc, dn, fv;
    logic ra, v, e;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 5; i++) load_words[i] = $urandom | 32'h1;
    drive_load(5, 4, 1'b1, 1'b1, acc, dn, fv, ra);
    n_compared++; if (acc != 5) begin n_mismatched++; $display("[TB] FAIL gappy_accepted: got %0d want 5", acc); end
    n_compared++; if (dn != 1) begin n_mismatched++; $display("[TB] FAIL gappy_done_pulses: got %0d want 1", dn); end
    n_compared++; if (fv != 0) begin n_mismatched++; $display("[TB] FAIL gappy_fetch_in_load: got %0d want 0", fv); end
    for (int i = 0; i < 5; i++) model_mem[i] = load_words[i];
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(ADDR_W'(i * WBYTES), v, d, e);
      n_compared++; if (d !== model_mem[i]) begin n_mismatched++; $display("[TB] FAIL gappy_word[%0d]: got %h want %h", i, d, model_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic v, e;
    logic [DATA_W-1:0] d, w;
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h24;
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    n_compared++; if (fetch_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_valid: got %b want 1", fetch_valid); end
    n_compared++; if (fetch_data !== model_mem[9]) begin n_mismatched++; $display("[TB] FAIL b2b_data: got %h want %h", fetch_data, model_mem[9]); end
    n_compared++; if (load_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_in_load: got %b want 1", load_ready); end
    w = $urandom | 32'h1;
    load_valid = 1'b1; load_data = w; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    n_compared++; if (load_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_done: got %b want 1", load_done); end
    model_mem[0] = w;
    step();
    applyStimulus(32'h0, v, d, e);
    n_compared++; if (d !== model_mem[0]) begin n_mismatched++; $display("[TB] FAIL b2b_word0: got %h want %h", d, model_mem[0]); end
  endtask

  task automatic test_reset_mid_load();
    int cnt;
    bit done_seen;
    logic v, e;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 5; i++) load_words[i] = $urandom | 32'h1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = load_words[i];
      step();
    end
    sys_rst = 1'b1; load_data = load_words[2];
    step();
    sys_rst = 1'b0; load_valid = 1'b0;
    cnt = 0; done_seen = 1'b0;
    while (busy && cnt < 100) begin
      if (load_done) done_seen = 1'b1;
      step();
      cnt++;
    end
    if (load_done) done_seen = 1'b1;
    n_compared++; if (cnt != DEPTH) begin n_mismatched++; $display("[TB] FAIL midload_clear_cycles: got %0d want %0d", cnt, DEPTH); end
    n_compared++; if (done_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midload_done: got %b want 0", done_seen); end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(ADDR_W'(i * WBYTES), v, d, e);
      n_compared++; if (d !== model_mem[i]) begin n_mismatched++; $display("[TB] FAIL midload_word[%0d]: got %h want %h", i, d, model_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_overflow();
    test_fetch_err();
    test_fetch_hold();
    test_gappy_load();
    test_back_to_back();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/inst_mem_ctrl.md
INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits; power of 2, at least 8.
REQ-002 Parameter DEPTH, default 16: number of words; power of 2, at least 2.
REQ-003 Parameter ADDR_W, default 32: fetch byte-address width; must be at least log2(DEPTH)+log2(DATA_W/8).
REQ-004 Port sys_clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port sys_rst, input, 1: reset, synchronous and active-high.
REQ-006 Port load_start, input, 1: request to begin a program load.
REQ-007 Port load_valid, input, 1: load_data and load_last are valid this cycle.
REQ-008 Port load_ready, output, 1: controller can accept a load word.
REQ-009 Port load_data, input, DATA_W: instruction word to store.
REQ-010 Port load_last, input, 1: the current load word is the final word.
REQ-011 Port load_done, output, 1: one-cycle pulse when a load completes.
REQ-012 Port fetch_req, input, 1: fetch request.
REQ-013 Port fetch_addr, input, ADDR_W: fetch byte address.
REQ-014 Port fetch_valid, output, 1: fetch_data and fetch_err are valid this cycle.
REQ-015 Port fetch_data, output, DATA_W: fetched word.
REQ-016 Port fetch_err, output, 1: fetch was out of range or misaligned.
REQ-017 Port busy, output, 1: high in CLEAR and LOAD; fetch requests are not accepted while high.

Function
REQ-018 The state machine SHALL have three states: CLEAR, IDLE and LOAD.
REQ-019 CLEAR SHALL write zero to word wr_ptr each cycle, incrementing wr_ptr from 0, and SHALL go to IDLE in the cycle after writing word DEPTH-1 (DEPTH cycles in total).
REQ-020 IDLE with load_start=1 SHALL go to LOAD and set wr_ptr=0; load_start SHALL be ignored in CLEAR and LOAD.
REQ-021 In LOAD, load_ready SHALL be 1; a word is accepted in any cycle with load_valid and load_ready both high; an accepted word SHALL be written to mem[wr_ptr] and wr_ptr SHALL increment.
REQ-022 When the accepted word has load_last=1 or wr_ptr=DEPTH-1, the controller SHALL go to IDLE and pulse load_done in the next cycle; words beyond DEPTH are never accepted.
REQ-023 Words not written during a load SHALL keep their previous contents.
REQ-024 A fetch SHALL be accepted only in IDLE with fetch_req=1; fetch_valid SHALL be 1 in the next cycle and 0 otherwise (fixed latency of one cycle, no backpressure).
REQ-025 Let BO = log2(DATA_W/8) and IW = log2(DEPTH); the word index SHALL be fetch_addr[BO+IW-1:BO].
REQ-026 A fetch is in range when fetch_addr[ADDR_W-1:BO+IW] is zero and aligned when fetch_addr[BO-1:0] is zero.
REQ-027 A fetch that is in range and aligned SHALL return fetch_data=mem[index] and fetch_err=0; any other fetch SHALL return fetch_data=0.
REQ-028 If load_start and fetch_req are both high in IDLE, the fetch SHALL be served normally and the state SHALL go to LOAD.
REQ-029 fetch_data and fetch_err SHALL hold their values while fetch_valid=0.

Reset
REQ-030 While sys_rst=1 the block SHALL enter CLEAR with wr_ptr=0, fetch_valid=0, fetch_data=0, fetch_err=0, load_done=0, load_ready=0 and busy=1.
REQ-031 Reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation and restart CLEAR, zeroing the whole memory.

Configuration
REQ-032 With INST_MEM_FETCH_ERR_EN defined, fetch_err SHALL be 1 for any out-of-range or misaligned fetch.
REQ-033 Without INST_MEM_FETCH_ERR_EN, fetch_err SHALL be constant 0, and range/alignment checking SHALL be limited to zero data on out-of-range; misaligned addresses SHALL then read the truncated index.

Structure
REQ-034 The state encoding typedef and the BO/IW derivation functions SHALL live in the shared package inst_mem_pkg.
REQ-035 The storage array SHALL be a sub-module inst_mem_array: one write port, one registered read port, no reset.

Verification
REQ-036 Reset then idle: busy=1 for exactly 16 cycles, then fetch 0x3C returns fetch_valid=1, fetch_data=0x00000000, fetch_err=0.
REQ-037 Load of 3 words 0x11,0x22,0x33 with last on the third: load_done pulses once; fetches 0x0, 0x4 and 0x8 return 0x11, 0x22 and 0x33 one cycle after the request.
REQ-038 Load of 20 words with no load_last: only 16 are accepted, load_ready drops after the 16th and load_done pulses; fetch 0x3C returns word 15.
REQ-039 Fetch 0x40 returns data 0 and fetch_err=1; fetch 0x2 returns data 0 and fetch_err=1 with the macro defined; with the macro undefined, fetch_err stays 0.
REQ-040 load_valid toggling 1-0-1 during a load: only the handshaken words are written, in order; fetch_req asserted during LOAD produces no fetch_valid.
REQ-041 Reset pulsed after 2 of 5 load words: the bench sees 16 CLEAR cycles, all words read 0 afterwards, and load_done never pulses.
